// File: rtl/ahb_lite_initiator.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined single-beat
// 64-bit AHB-Lite transfers and returns one in-order response pulse per command.
// The address phase of transfer N+1 overlaps the data phase of transfer N.
//
// Ports
//   hclk_i, hresetn_i      bus clock, asynchronous active-low reset
//   cmd_*_i / cmd_ready_o  command stream (write, addr, size, data_acc, wdata, tag)
//   rsp_*_o                one-cycle response pulse (err, rdata, tag), no backpressure
//   h*_o                   AHB-Lite address/control and write data
//   hrdata_i, hready_i, hresp_i  AHB-Lite slave response
module ahb_lite_initiator #(
  parameter int unsigned TagW = 4
) (
  input  logic            hclk_i,
  input  logic            hresetn_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_write_i,
  input  logic [31:0]     cmd_addr_i,
  input  logic [1:0]      cmd_size_i,
  input  logic            cmd_data_acc_i,
  input  logic [63:0]     cmd_wdata_i,
  input  logic [TagW-1:0] cmd_tag_i,
  output logic            rsp_valid_o,
  output logic            rsp_err_o,
  output logic [63:0]     rsp_rdata_o,
  output logic [TagW-1:0] rsp_tag_o,
  output logic [31:0]     haddr_o,
  output logic [1:0]      htrans_o,
  output logic            hwrite_o,
  output logic [2:0]      hsize_o,
  output logic [2:0]      hburst_o,
  output logic [3:0]      hprot_o,
  output logic            hmastlock_o,
  output logic [63:0]     hwdata_o,
  input  logic [63:0]     hrdata_i,
  input  logic            hready_i,
  input  logic            hresp_i
);

  localparam logic [1:0] HTransIdle   = 2'b00;
  localparam logic [1:0] HTransNonseq = 2'b10;

  // Address-phase stage (A). HADDR/HWRITE/HSIZE/HPROT double as A's control fields.
  logic            a_v_q, a_v_d;
  logic [TagW-1:0] a_tag_q, a_tag_d;
  logic [63:0]     a_wdata_q, a_wdata_d;
  logic [31:0]     haddr_q, haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [2:0]      hsize_q, hsize_d;
  logic [3:0]      hprot_q, hprot_d;
  // Data-phase stage (D); its write data is HWDATA itself.
  logic            d_v_q, d_v_d;
  logic [TagW-1:0] d_tag_q, d_tag_d;
  logic            d_write_q, d_write_d;
  logic [63:0]     hwdata_q, hwdata_d;
  // Pending misaligned command.
  logic            m_q, m_d;
  logic [TagW-1:0] m_tag_q, m_tag_d;
  // Registered response.
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [63:0]     rsp_rdata_q, rsp_rdata_d;
  logic [TagW-1:0] rsp_tag_q, rsp_tag_d;

  logic misaligned, accept, accept_bus, accept_mis, d_done, mis_rsp;

  always_comb begin
    unique case (cmd_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = cmd_addr_i[0];
      2'd2:    misaligned = |cmd_addr_i[1:0];
      default: misaligned = |cmd_addr_i[2:0];
    endcase
  end

  // Gated by reset so nothing is accepted while the bus is held in reset.
  assign cmd_ready_o = hresetn_i & (~a_v_q | hready_i) & ~m_q;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign accept_bus  = accept & ~misaligned;
  assign accept_mis  = accept & misaligned;
  assign d_done      = d_v_q & hready_i;
  // A misaligned response waits until everything ahead of it has fully drained.
  assign mis_rsp     = m_q & ~a_v_q & ~d_v_q & ~rsp_valid_q;

  always_comb begin
    a_v_d       = a_v_q;
    a_tag_d     = a_tag_q;
    a_wdata_d   = a_wdata_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    d_v_d       = d_v_q;
    d_tag_d     = d_tag_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    m_d         = m_q;
    m_tag_d     = m_tag_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tag_d   = rsp_tag_q;

    // D takes A's contents (old control values) at every HREADY edge.
    if (hready_i) begin
      d_v_d = a_v_q;
      if (a_v_q) begin
        d_tag_d   = a_tag_q;
        d_write_d = hwrite_q;
        hwdata_d  = a_wdata_q;
      end
    end

    if (accept_bus) begin
      a_v_d     = 1'b1;
      a_tag_d   = cmd_tag_i;
      a_wdata_d = cmd_wdata_i;
      haddr_d   = cmd_addr_i;
      hwrite_d  = cmd_write_i;
      hsize_d   = {1'b0, cmd_size_i};
      hprot_d   = {2'b00, 1'b1, cmd_data_acc_i};
    end else if (hready_i) begin
      a_v_d = 1'b0;
    end

    if (accept_mis) begin
      m_d     = 1'b1;
      m_tag_d = cmd_tag_i;
    end

    if (d_done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = hresp_i;
      rsp_rdata_d = (~d_write_q & ~hresp_i) ? hrdata_i : 64'd0;
      rsp_tag_d   = d_tag_q;
    end else if (mis_rsp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = 64'd0;
      rsp_tag_d   = m_tag_q;
      m_d         = 1'b0;
    end
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      a_v_q       <= 1'b0;
      a_tag_q     <= '0;
      a_wdata_q   <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hprot_q     <= '0;
      d_v_q       <= 1'b0;
      d_tag_q     <= '0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      m_q         <= 1'b0;
      m_tag_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_tag_q   <= '0;
    end else begin
      a_v_q       <= a_v_d;
      a_tag_q     <= a_tag_d;
      a_wdata_q   <= a_wdata_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      d_v_q       <= d_v_d;
      d_tag_q     <= d_tag_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      m_q         <= m_d;
      m_tag_q     <= m_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign htrans_o    = a_v_q ? HTransNonseq : HTransIdle;
  assign haddr_o     = haddr_q;
  assign hwrite_o    = hwrite_q;
  assign hsize_o     = hsize_q;
  assign hburst_o    = 3'b000;
  assign hprot_o     = hprot_q;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = hwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_tag_o   = rsp_tag_q;

endmodule

// File: doc/ahb_lite_initiator.md
# ahb_lite_initiator

Single-outstanding-per-phase AHB-Lite master that turns a valid/ready command stream into pipelined 64-bit single-beat AHB-Lite transfers and returns an in-order response pulse per command. It is the bus-initiating end of the AHB-Lite memory slaves used on the testbench side. It drives LSU/IFU-style traffic for DMA-like agents, bus stress and error-injection benches. Address phase of transfer N+1 overlaps data phase of transfer N.

## Interface
- TAGW, 4, width of command tag echoed on the response
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at HCLK rise
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- cmd_data_acc  in  1  1 = data access, 0 = opcode fetch (drives HPROT[0])
- cmd_wdata  in  64  write data, already placed on its byte lanes
- cmd_tag  in  TAGW  opaque tag
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_err  out  1  bus error or misaligned command
- rsp_rdata  out  64  HRDATA captured at read completion (0 for writes and errors)
- rsp_tag  out  TAGW  tag of the responding command
- HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HMASTLOCK  out  1; HWDATA  out  64
- HRDATA  in  64; HREADY  in  1; HRESP  in  1

## Operation
- Two pipeline registers: A (address phase) and D (data phase), each with valid bit, tag, write flag and wdata. A third flag, M, marks a pending misaligned command.
- cmd_ready = (~A.v | HREADY) & ~M & ~(A.v & A.mis). Acceptance loads A. A well-aligned command drives HTRANS = NONSEQ (2'b10) from the next cycle.
- Misaligned means size 1 with addr[0] set, size 2 with addr[1:0] != 0, or size 3 with addr[2:0] != 0. Such a command is accepted but never reaches the bus and sets M. While M is set, cmd_ready = 0.
- The misaligned response (rsp_err = 1, rsp_rdata = 0) issues in the first cycle in which A, D and any earlier response are all empty. M clears at that same edge.
- Constant outputs: HBURST = 3'b000, HMASTLOCK = 0, HSIZE = {1'b0, size}, HPROT = {2'b00, 1'b1, cmd_data_acc}.
- When A is empty, HTRANS = IDLE (2'b00). HADDR, HWRITE, HSIZE and HPROT hold their last values.
- Address phase completes at a rising edge with HREADY = 1. A moves to D, and HWDATA = D.wdata from that edge.
- Data phase completes at a rising edge with HREADY = 1. At that edge rsp_valid, rsp_err (= HRESP), rsp_rdata (= read & ~HRESP ? HRDATA : 0) and rsp_tag are registered and shown in the next cycle.
- While HREADY = 0, all address/control outputs and HWDATA are held stable.
- Error response (HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1):
  - the pipelined transfer in A is not cancelled and proceeds normally;
  - only the erroring transfer gets rsp_err = 1.
- Responses are strictly in command order.

## Timing
- Reset values (asynchronous, immediate): HTRANS = 0, HADDR = 0, HWRITE = 0, HSIZE = 0, HBURST = 0, HPROT = 0, HMASTLOCK = 0, HWDATA = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, rsp_tag = 0, A/D/M cleared.
- cmd_ready is combinational from HREADY, A and M. During reset it is 0.
- Latency with zero wait states:
  - command accepted at edge E0;
  - NONSEQ in the cycle after E0;
  - data phase in the cycle after E1;
  - rsp_valid in the cycle after E2.
  Each wait state adds one cycle.
- Back-to-back throughput is one command per cycle when HREADY = 1 continuously.
- Simultaneous events at one edge are legal and must all take effect: D completes, A advances to D, and a new command loads A.
- Reset asserted mid-transfer: in-flight commands are dropped with no response. The bus returns to IDLE immediately.
- The HRDATA value during HREADY = 0 is never captured.

## Test plan
- Write then read, zero wait states:
  - write addr 0x1000, size 3, wdata 0x0123456789ABCDEF, tag 1;
  - then read 0x1000, tag 2;
  - required: two responses, err = 0, the second with rdata 0x0123456789ABCDEF and tag 2;
  - required: exactly one NONSEQ per command, and the second NONSEQ overlaps the write's data phase.
- Wait states: slave inserts 3 wait states on the read of 0x1004 size 2.
  - required: HADDR/HTRANS/HWDATA stable through the waits;
  - required: rsp_valid exactly 5 cycles after acceptance.
- Stream of 8 reads at 0x2000 + 8·i, tags 0..7, HREADY = 1 throughout:
  - required: cmd_ready high every cycle;
  - required: responses in 8 consecutive cycles with tags 0..7 in order.
- Error: slave returns the two-cycle HRESP on a write to 0x3000, tag 5, with a read to 0x3008 (tag 6) pipelined behind it.
  - required: tag 5 rsp_err = 1;
  - required: tag 6 completes with rsp_err = 0 and correct data.
- Misaligned: read 0x1002, size 2, issued while one transfer is in flight.
  - required: no NONSEQ issued for it and cmd_ready = 0 until its response;
  - required: its response (rsp_err = 1, rdata 0) follows the in-flight response.
- Reset mid-data-phase: pull HRESETn low while a wait-stated read is in its data phase.
  - required: HTRANS = 0 immediately, and no rsp_valid during or after reset;
  - required: a new command after reset completes normally.
